// File: rtl/jtvigil_pal_arbiter.sv
// Palette RAM arbiter: time-shares one 2k x 8 synchronous RAM between the per-pixel
// R/G/B plane fetch and main-CPU palette accesses, using an 8-clock pixel phase counter.
module jtvigil_pal_arbiter #(
    parameter int unsigned CPU_SLOTS = 2
) (
    input  logic        rst,
    input  logic        clk,
    output logic        pxl_cen,
    input  logic        pal_sel,
    input  logic [7:0]  pal_base,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic        cpu_cs,
    input  logic        cpu_rnw,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } cpu_state_e;

    logic [2:0]  sub;
    logic        sel_l;
    logic [7:0]  base_l;
    logic [4:0]  pre_r;
    logic [4:0]  pre_g;
    logic [4:0]  pre_b;
    logic [10:0] addr_l;
    logic [7:0]  din_l;
    logic        rd_l;
    logic        slot;
    logic        grant;
    logic        blank;
    cpu_state_e  state;
    cpu_state_e  state_nx;

    assign pxl_cen = (sub == 3'd7);
    assign blank   = !LHBL || !LVBL;

    always_comb begin
        slot = (sub == 3'd3);
        if (CPU_SLOTS == 2 && sub == 3'd5) begin
            slot = 1'b1;
        end
    end

    assign grant = (state == StIdle) && cpu_cs && slot;

    // Pixel phase counter, plane captures and output latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub    <= 3'd0;
            sel_l  <= 1'b0;
            base_l <= 8'd0;
            pre_r  <= 5'd0;
            pre_g  <= 5'd0;
            pre_b  <= 5'd0;
            red    <= 5'd0;
            green  <= 5'd0;
            blue   <= 5'd0;
        end else begin
            sub <= sub + 3'd1;
            case (sub)
                3'd1: pre_r <= ram_dout[4:0];
                3'd2: pre_g <= ram_dout[4:0];
                3'd3: pre_b <= ram_dout[4:0];
                3'd7: begin
                    sel_l  <= pal_sel;
                    base_l <= pal_base;
                    red    <= blank ? 5'd0 : pre_r;
                    green  <= blank ? 5'd0 : pre_g;
                    blue   <= blank ? 5'd0 : pre_b;
                end
                default: ;
            endcase
        end
    end

    // Fetch owns sub0..2; a granted CPU slot owns the bus; otherwise hold the last address
    always_comb begin
        if (grant) begin
            ram_addr = cpu_addr;
        end else if (sub < 3'd3) begin
            ram_addr = {sel_l, sub[1:0], base_l};
        end else begin
            ram_addr = addr_l;
        end
    end

    assign ram_we  = grant && !cpu_rnw;
    assign ram_din = cpu_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_l <= 11'd0;
            din_l  <= 8'd0;
            rd_l   <= 1'b0;
            state  <= StIdle;
        end else begin
            addr_l <= ram_addr;
            state  <= state_nx;
            if (grant) begin
                rd_l <= cpu_rnw;
            end
            if (state == StBusy && rd_l) begin
                din_l <= ram_dout;
            end
        end
    end

    // BUSY with cs already low has seen cs at 0, so it may skip DONE and be regranted next slot
    always_comb begin
        state_nx = state;
        cpu_ack  = 1'b0;
        unique case (state)
            StIdle: begin
                if (grant) begin
                    state_nx = StBusy;
                end
            end
            StBusy: begin
                cpu_ack  = cpu_cs;
                state_nx = cpu_cs ? StDone : StIdle;
            end
            StDone: begin
                if (!cpu_cs) begin
                    state_nx = StIdle;
                end
            end
            default: state_nx = StIdle;
        endcase
    end

    assign cpu_din = (state == StBusy && rd_l) ? ram_dout : din_l;

endmodule

// File: tb/tb_jtvigil_pal_arbiter.sv
// Directed bench for jtvigil_pal_arbiter with a behavioural synchronous palette RAM.
module tb_jtvigil_pal_arbiter;

    logic        rst;
    logic        clk;
    logic        pxl_cen;
    logic        pal_sel;
    logic [7:0]  pal_base;
    logic        LHBL;
    logic        LVBL;
    logic        cpu_cs;
    logic        cpu_rnw;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [4:0]  red;
    logic [4:0]  green;
    logic [4:0]  blue;

    logic [7:0]  mem [0:2047];
    logic        preload;
    logic [2:0]  phase;
    int          n_tests;
    int          n_fail;

    jtvigil_pal_arbiter #(.CPU_SLOTS(2)) dut (
        .rst      (rst),
        .clk      (clk),
        .pxl_cen  (pxl_cen),
        .pal_sel  (pal_sel),
        .pal_base (pal_base),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .cpu_cs   (cpu_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .cpu_ack  (cpu_ack),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM, preloaded while the bench holds preload
    always @(posedge clk) begin
        if (preload) begin
            mem[11'h000] <= 8'h00;
            mem[11'h100] <= 8'h00;
            mem[11'h200] <= 8'h00;
            mem[11'h012] <= 8'h1F;
            mem[11'h112] <= 8'h0A;
            mem[11'h212] <= 8'h05;
            mem[11'h412] <= 8'h00;
            mem[11'h013] <= 8'h00;
            mem[11'h014] <= 8'h00;
            mem[11'h020] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    // Reference phase: sub is 0 out of reset and counts every clock
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 3'd0;
        else     phase <= phase + 3'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] p);
        int n;
        n = 0;
        step();
        while (phase != p && n < 16) begin
            step();
            n++;
        end
        if (phase != p) check("wait_phase", {29'd0, phase}, {29'd0, p});
    endtask

    initial begin
        int first_hi;
        int acks;
        logic [7:0] rd_val;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        preload  = 1'b1;
        pal_sel  = 1'b0;
        pal_base = 8'h00;
        LHBL     = 1'b1;
        LVBL     = 1'b1;
        cpu_cs   = 1'b0;
        cpu_rnw  = 1'b1;
        cpu_addr = 11'h000;
        cpu_dout = 8'h00;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        #1;
        check("rst_red", red, 0);
        check("rst_green", green, 0);
        check("rst_blue", blue, 0);
        check("rst_ack", cpu_ack, 0);
        check("rst_din", cpu_din, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_cen", pxl_cen, 0);

        // Release: this cycle is clk 1 (sub0); pxl_cen must first rise on clk 8
        rst = 1'b0;
        first_hi = 0;
        for (int n = 1; n <= 16; n++) begin
            if (pxl_cen && first_hi == 0) first_hi = n;
            if (n < 16) step();
        end
        check("cen_first", first_hi, 8);

        // Now in sub7: this index is latched at the end of the cycle
        pal_base = 8'h12;
        step();
        check("fetch_r_addr", ram_addr, 11'h012);
        step();
        check("fetch_g_addr", ram_addr, 11'h112);
        step();
        check("fetch_b_addr", ram_addr, 11'h212);
        repeat (5) step();
        check("latency_old_red", red, 0);
        step();
        check("pix_red", red, 5'h1F);
        check("pix_green", green, 5'h0A);
        check("pix_blue", blue, 5'h05);

        // Horizontal blank forces black while fetches carry on unchanged
        LHBL = 1'b0;
        step();
        check("blank_r_addr", ram_addr, 11'h112);
        repeat (7) step();
        check("blank_red", red, 0);
        check("blank_green", green, 0);
        check("blank_blue", blue, 0);
        LHBL = 1'b1;
        repeat (8) step();
        check("unblank_green", green, 5'h0A);

        // CPU write raised at sub0: grant at sub3, ack at sub4, held cs not repeated
        wait_phase(3'd0);
        cpu_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = 11'h412;
        cpu_dout = 8'h3C;
        #1;
        check("wr_we_sub0", ram_we, 0);
        step();
        check("wr_we_sub1", ram_we, 0);
        step();
        check("wr_we_sub2", ram_we, 0);
        step();
        check("wr_we_sub3", ram_we, 1);
        check("wr_addr_sub3", ram_addr, 11'h412);
        check("wr_din_sub3", ram_din, 8'h3C);
        step();
        check("wr_ack_sub4", cpu_ack, 1);
        check("wr_we_sub4", ram_we, 0);
        step();
        check("wr_ack_sub5", cpu_ack, 0);
        check("wr_we_sub5", ram_we, 0);
        cpu_cs = 1'b0;
        step();
        check("wr_mem", mem[11'h412], 8'h3C);

        // Read with cs held for 40 clocks: exactly one ack carrying the data
        cpu_cs   = 1'b1;
        cpu_rnw  = 1'b1;
        cpu_addr = 11'h412;
        #1;
        acks   = 0;
        rd_val = 8'h00;
        for (int i = 0; i < 40; i++) begin
            if (cpu_ack) begin
                acks++;
                rd_val = cpu_din;
            end
            step();
        end
        check("rd_ack_count", acks, 1);
        check("rd_data", rd_val, 8'h3C);
        cpu_cs = 1'b0;
        step();
        step();

        // Drop cs right after a write grant: no ack, write lands, regrant at sub5
        wait_phase(3'd2);
        cpu_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = 11'h013;
        cpu_dout = 8'h55;
        step();
        check("drop_we_sub3", ram_we, 1);
        check("drop_addr_sub3", ram_addr, 11'h013);
        step();
        cpu_cs = 1'b0;
        #1;
        check("drop_no_ack", cpu_ack, 0);
        step();
        cpu_cs   = 1'b1;
        cpu_addr = 11'h014;
        cpu_dout = 8'h66;
        #1;
        check("regrant_we_sub5", ram_we, 1);
        check("regrant_addr_sub5", ram_addr, 11'h014);
        step();
        check("regrant_ack_sub6", cpu_ack, 1);
        cpu_cs = 1'b0;
        step();
        check("drop_mem", mem[11'h013], 8'h55);
        check("regrant_mem", mem[11'h014], 8'h66);
        check("pre_rst_red", red, 5'h1F);

        // Reset at sub2 with a write pending: outputs clear at once, nothing is written
        wait_phase(3'd2);
        cpu_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = 11'h020;
        cpu_dout = 8'h77;
        rst      = 1'b1;
        #1;
        check("midrst_red", red, 0);
        check("midrst_green", green, 0);
        check("midrst_blue", blue, 0);
        check("midrst_din", cpu_din, 0);
        check("midrst_addr", ram_addr, 0);
        check("midrst_we", ram_we, 0);
        check("midrst_cen", pxl_cen, 0);
        step();
        step();
        check("inrst_we", ram_we, 0);
        check("inrst_ack", cpu_ack, 0);
        cpu_cs = 1'b0;
        rst    = 1'b0;
        acks   = 0;
        for (int i = 0; i < 16; i++) begin
            if (cpu_ack) acks++;
            step();
        end
        check("postrst_acks", acks, 0);
        check("postrst_mem", mem[11'h020], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests,
                 n_fail);
        $fatal(1, "watchdog");
    end

endmodule
